// File: rtl/keypad_lock_if.sv
// Keypad lock bus: key events toward the controller, status back from it.
interface keypad_lock_if #(
    parameter int PW_LEN = 4
);
    logic              key_valid;
    logic [3:0]        key_code;
    logic [PW_LEN-1:0] password_led;
    logic [2:0]        state;
    logic              unlocked;
    logic              alarm;

    // Key source side (encoder / testbench)
    modport master (
        output key_valid, key_code,
        input  password_led, state, unlocked, alarm
    );

    // Lock controller side
    modport slave (
        input  key_valid, key_code,
        output password_led, state, unlocked, alarm
    );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Keypad safe controller: PW_LEN-digit password check, in-field password
// change, consecutive-failure counter with timed lockout, thermometer LED.
module keypad_lock_ctrl #(
    parameter int                  PW_LEN         = 4,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 1000,
    parameter logic [4*PW_LEN-1:0] DEFAULT_PW     = '0
) (
    input  logic         clk,
    input  logic         reset,
    keypad_lock_if.slave kp
);
    localparam int CW = $clog2(PW_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SET_NEW = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [4*PW_LEN-1:0] pw_q, pw_d;
    logic [4*PW_LEN-1:0] buf_q, buf_d;
    logic [CW-1:0]       count_q, count_d;
    logic [FW-1:0]       fail_cnt_q, fail_cnt_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic                is_digit, is_star, is_hash, full;
    logic [4*PW_LEN-1:0] buf_app;
    logic [CW-1:0]       count_app;
    logic [FW-1:0]       fail_inc;

    // Key decode; codes 12-15 decode to nothing and therefore never act
    always_comb begin
        is_digit = kp.key_valid && (kp.key_code <= 4'd9);
        is_star  = kp.key_valid && (kp.key_code == 4'd10);
        is_hash  = kp.key_valid && (kp.key_code == 4'd11);
        full     = (count_q == CW'(PW_LEN));
        fail_inc = (fail_cnt_q == FW'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + FW'(1);
    end

    // Buffer/count after appending the current digit; a full buffer holds
    always_comb begin
        buf_app   = buf_q;
        count_app = count_q;
        if (!full) begin
            for (int i = 0; i < PW_LEN; i++) begin
                if (count_q == CW'(i)) begin
                    buf_app[4*i +: 4] = kp.key_code;
                end
            end
            count_app = count_q + CW'(1);
        end
    end

    // Next-state logic; buffer is cleared on every transition out of entry
    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        buf_d      = buf_q;
        count_d    = count_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        case (state_q)
            ST_LOCKED: begin
                if (is_digit) begin
                    buf_d   = buf_app;
                    count_d = count_app;
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (is_digit) begin
                    buf_d   = buf_app;
                    count_d = count_app;
                end else if (is_star) begin
                    buf_d   = '0;
                    count_d = '0;
                    state_d = ST_LOCKED;
                end else if (is_hash) begin
                    buf_d   = '0;
                    count_d = '0;
                    timer_d = '0;
                    if (full && (buf_q == pw_q)) begin
                        fail_cnt_d = '0;
                        state_d    = ST_OPEN;
                    end else begin
                        fail_cnt_d = fail_inc;
                        state_d    = (fail_inc == FW'(MAX_FAIL)) ? ST_LOCKOUT : ST_LOCKED;
                    end
                end
            end
            ST_OPEN: begin
                if (is_hash) begin
                    state_d = ST_LOCKED;
                end else if (is_star) begin
                    buf_d   = '0;
                    count_d = '0;
                    state_d = ST_SET_NEW;
                end
            end
            ST_SET_NEW: begin
                if (is_digit) begin
                    buf_d   = buf_app;
                    count_d = count_app;
                end else if (is_hash || is_star) begin
                    // A short new password is discarded; '*' always aborts
                    if (is_hash && full) begin
                        pw_d = buf_q;
                    end
                    buf_d   = '0;
                    count_d = '0;
                    state_d = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    timer_d    = '0;
                    fail_cnt_d = '0;
                    state_d    = ST_LOCKED;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                // Unused encodings fall back to a clean LOCKED
                buf_d   = '0;
                count_d = '0;
                timer_d = '0;
                state_d = ST_LOCKED;
            end
        endcase
    end

    // State registers; reset wins over any key in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOCKED;
            pw_q       <= DEFAULT_PW;
            buf_q      <= '0;
            count_q    <= '0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
        end
    end

    // Outputs are pure decodes of registered state (one-cycle key latency)
    always_comb begin
        kp.state        = state_q;
        kp.unlocked     = (state_q == ST_OPEN) || (state_q == ST_SET_NEW);
        kp.alarm        = (state_q == ST_LOCKOUT);
        kp.password_led = '0;
        if ((state_q == ST_ENTRY) || (state_q == ST_SET_NEW)) begin
            for (int i = 0; i < PW_LEN; i++) begin
                kp.password_led[i] = (count_q > CW'(i));
            end
        end
    end
endmodule
